// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU pipeline: opcode encoding, NZCV flag
// bit positions and FSM state encoding.
package alu_pkg;

    // ALUControl encoding
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_ORR = 3'b011,
        OP_MUL = 3'b100,
        OP_EOR = 3'b101,
        OP_MVN = 3'b110,
        OP_RSV = 3'b111
    } alu_op_e;

    // NZCV bit positions within ALUFlags
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        HOLD = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// Producer/consumer bus of alu_pipe: operand handshake in, result handshake out.
// The slave modport is the ALU side, the master modport the surrounding pipeline.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic [3:0]       ALUFlags;
    logic             busy;

    modport slave (
        input  in_valid, a, b, ALUControl, out_ready,
        output in_ready, out_valid, ALUResult, ALUFlags, busy
    );

    modport master (
        output in_valid, a, b, ALUControl, out_ready,
        input  in_ready, out_valid, ALUResult, ALUFlags, busy
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, low WIDTH
// bits of the unsigned product. o_done is asserted during the cycle of the
// final step and o_product then already includes that step, so the caller
// can capture the result on the same edge the last step would complete.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             r_run;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_acc_next;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;
    assign o_done     = r_run & (r_cnt == CNT_W'(WIDTH - 1));
    assign o_product  = w_acc_next;

    // Iteration control: run flag and step counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
        end else if (r_run) begin
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

    // Operand shifters and accumulator; contents only matter while running
    always_ff @(posedge i_clk) begin
        if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_run) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered result/flags stage. Non-MUL ops complete
// with latency 1 at full throughput; MUL runs on the iterative multiplier.
// Build option: define ALU_MUL_EN to implement MUL (100); without it the
// multiplier is not built, busy is tied 0 and 100 behaves as reserved.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    alu_pipe_if.slave bus
);
    alu_state_e       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    alu_op_e          w_op;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic [3:0]       w_flags;
    logic             w_busy;
    logic             w_accept;

    // Pack N/Z from the result together with the supplied C and V
    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    // Signed overflow: like-signed operands producing a different sign
    function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) & (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow of x - y: unlike-signed operands, result sign differs from x
    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) & (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign w_op     = alu_op_e'(bus.ALUControl);
    assign w_is_sub = (w_op == OP_SUB);

    // Single shared adder: SUB is a + ~b + 1
    assign w_b_eff  = w_is_sub ? ~bus.b : bus.b;
    assign w_sum    = {1'b0, bus.a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};

`ifdef ALU_MUL_EN
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod;

    assign w_mul_start = w_accept & (w_op == OP_MUL);
    assign w_busy      = (r_state == MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_start   (w_mul_start),
        .i_a       (bus.a),
        .i_b       (bus.b),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );
`else
    assign w_busy = 1'b0;
`endif

    // Accept when not multiplying and the output slot is empty or draining now
    assign bus.in_ready = reset & ~w_busy & (~r_out_valid | bus.out_ready);
    assign w_accept     = bus.in_valid & bus.in_ready;

    // Single-cycle result and flags; MUL and reserved codes land in default
    always_comb begin
        w_res   = '0;
        w_flags = '0;
        case (w_op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_flags = make_flags(w_res, w_sum[WIDTH], add_ovf(bus.a, bus.b, w_res));
            end
            OP_SUB: begin
                w_res   = w_sum[WIDTH-1:0];
                w_flags = make_flags(w_res, w_sum[WIDTH], sub_ovf(bus.a, bus.b, w_res));
            end
            OP_AND: begin
                w_res   = bus.a & bus.b;
                w_flags = make_flags(w_res, 1'b0, 1'b0);
            end
            OP_ORR: begin
                w_res   = bus.a | bus.b;
                w_flags = make_flags(w_res, 1'b0, 1'b0);
            end
            OP_EOR: begin
                w_res   = bus.a ^ bus.b;
                w_flags = make_flags(w_res, 1'b0, 1'b0);
            end
            OP_MVN: begin
                w_res   = ~bus.b;
                w_flags = make_flags(w_res, 1'b0, 1'b0);
            end
            default: begin
                w_res   = '0;
                w_flags = '0;
            end
        endcase
    end

    // Control FSM with the registered result/flags output stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else if (r_out_valid) begin
                        r_state     <= HOLD;
                    end
                    if (w_accept) begin
`ifdef ALU_MUL_EN
                        if (w_op == OP_MUL) begin
                            r_state <= MUL;
                        end else
`endif
                        begin
                            r_result    <= w_res;
                            r_flags     <= w_flags;
                            r_out_valid <= 1'b1;
                            r_state     <= bus.out_ready ? IDLE : HOLD;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    if (w_mul_done) begin
                        r_result    <= w_mul_prod;
                        r_flags     <= make_flags(w_mul_prod, 1'b0, 1'b0);
                        r_out_valid <= 1'b1;
                        r_state     <= bus.out_ready ? IDLE : HOLD;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.ALUResult = r_result;
    assign bus.ALUFlags  = r_flags;
    assign bus.busy      = w_busy;

endmodule
